row_max_tracker: RTL and testbench

Streaming reduction unit for the matrix accelerator's 4-bit datapath. Accepts one row of unsigned elements per frame over a valid/ready input and returns the row maximum, the index of its first occurrence, and the count of elements equal to that maximum over a valid/ready output. It sits downstream of the multiply/accumulate row output and feeds result-selection logic. It reuses the team's bitwise greater-than and equality primitives as its compare core.

---
 rtl/row_max_tracker_pkg.sv | 25 ++
 rtl/row_max_tracker_mag_compare.sv | 34 +++
 rtl/row_max_tracker.sv | 114 +++++++++++
 tb/tb_row_max_tracker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/row_max_tracker_pkg.sv
// Shared definitions for the row maximum tracker.
//   DATA_W_DEF / ROW_LEN_DEF : default element width and row length
//   state_e                  : two-state FSM encoding (COLLECT, HOLD)
//   idx_w / eqcnt_w          : widths of the index and equal-count fields
package row_max_tracker_pkg;

  localparam int DATA_W_DEF  = 4;
  localparam int ROW_LEN_DEF = 4;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Index of an element within a row; kept at least one bit wide.
  function automatic int idx_w(input int row_len);
    return (row_len > 1) ? $clog2(row_len) : 1;
  endfunction

  // Count of elements equal to the maximum, 1..row_len inclusive.
  function automatic int eqcnt_w(input int row_len);
    return $clog2(row_len + 1);
  endfunction

endpackage

// File: rtl/row_max_tracker_mag_compare.sv
// Unsigned magnitude comparator built from per-bit greater-than and xnor
// terms, scanning from the MSB down.
//   a, b : operands (DATA_W bits, unsigned)
//   gt   : a > b
//   eq   : a == b
module mag_compare #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt,
  output logic              eq
);

  logic [DATA_W-1:0] bit_gt;
  logic [DATA_W-1:0] bit_eq;

  assign bit_gt = a & ~b;
  assign bit_eq = ~(a ^ b);

  // gt fires at the first (highest) bit where a wins while every bit above
  // it is equal; eq_hi carries the "all higher bits equal" term downwards.
  always_comb begin
    logic eq_hi;
    gt    = 1'b0;
    eq_hi = 1'b1;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      gt    = gt | (eq_hi & bit_gt[i]);
      eq_hi = eq_hi & bit_eq[i];
    end
    eq = eq_hi;
  end

endmodule

// File: rtl/row_max_tracker.sv
// Streaming row reduction: accepts ROW_LEN unsigned elements per row and
// returns the maximum, the index of its first occurrence and the number of
// elements equal to it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous abort of the row in progress
//   in_valid/in_ready   : element handshake, in_data carries the element
//   out_valid/out_ready : result handshake, out_max/out_idx/out_eqcnt
//   dbg_state           : current FSM state
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high; valid, once raised, holds its payload
// stable until that transfer occurs.
module row_max_tracker
  import row_max_tracker_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROW_LEN = ROW_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_max,
  output logic [idx_w(ROW_LEN)-1:0]     out_idx,
  output logic [eqcnt_w(ROW_LEN)-1:0]   out_eqcnt,
  output state_e                        dbg_state
);

  localparam int IDX_W = idx_w(ROW_LEN);
  localparam int EQ_W  = eqcnt_w(ROW_LEN);

  state_e            state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] run_max, nxt_max;
  logic [IDX_W-1:0]  run_idx, nxt_idx;
  logic [EQ_W-1:0]   run_eq, nxt_eq;
  logic              gt, eq;
  logic              accept, first, last;

  mag_compare #(.DATA_W(DATA_W)) u_cmp (
    .a  (in_data),
    .b  (run_max),
    .gt (gt),
    .eq (eq)
  );

  // In HOLD a new element may only enter while the held result leaves on
  // the same edge, which gives zero-bubble row-to-row throughput.
  assign in_ready  = ((state == COLLECT) || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign first     = (cnt == '0);
  assign last      = (cnt == IDX_W'(ROW_LEN - 1));
  assign dbg_state = state;

  // Running values including the element being accepted this cycle. The
  // first element of a row overrides whatever the running registers hold,
  // so a flush only needs to clear the counter.
  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    nxt_eq  = run_eq;
    if (first) begin
      nxt_max = in_data;
      nxt_idx = '0;
      nxt_eq  = EQ_W'(1);
    end else if (gt) begin
      nxt_max = in_data;
      nxt_idx = cnt;
      nxt_eq  = EQ_W'(1);
    end else if (eq) begin
      nxt_eq  = run_eq + EQ_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      run_eq    <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
      out_eqcnt <= '0;
    end else begin
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        run_max <= nxt_max;
        run_idx <= nxt_idx;
        run_eq  <= nxt_eq;
        cnt     <= last ? '0 : cnt + IDX_W'(1);
      end

      // A completing row takes priority over the consumer draining HOLD.
      if (accept && last) begin
        out_max   <= nxt_max;
        out_idx   <= nxt_idx;
        out_eqcnt <= nxt_eq;
        out_valid <= 1'b1;
        state     <= HOLD;
      end else if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
        state     <= COLLECT;
      end
    end
  end

endmodule

// File: tb/tb_row_max_tracker.sv
module tb_row_max_tracker;
  import row_max_tracker_pkg::*;

  localparam int DW = 4;
  localparam int RL = 4;
  localparam int IW = 2;
  localparam int EW = 3;
  localparam int RW = DW + IW + EW;

  logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_max;
  logic [IW-1:0] out_idx;
  logic [EW-1:0] out_eqcnt;
  state_e dbg_state;

  int checks   = 0;
  int failures = 0;
  bit rand_mode = 0;

  logic [RW-1:0] exp_q[$];   // expected pending result (model)
  logic [RW-1:0] got_q[$];   // results actually handed off by the DUT
  logic [DW-1:0] row_q[$];   // elements of the row being collected (model)

  row_max_tracker #(.DATA_W(DW), .ROW_LEN(RL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx), .out_eqcnt(out_eqcnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] row_result(input logic [DW-1:0] r[$]);
    int m = 0, ix = 0, c = 0;
    foreach (r[i]) if (int'(r[i]) > m) m = int'(r[i]);
    ix = -1;
    foreach (r[i]) if (int'(r[i]) == m) begin
      c++;
      if (ix < 0) ix = i;
    end
    return {DW'(m), IW'(ix), EW'(c)};
  endfunction

  function automatic logic model_ready();
    return !flush && (exp_q.size() == 0 || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      row_q.delete();
    end else begin
      logic rdy;
      rdy = model_ready();
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (flush) row_q.delete();
      else if (in_valid && rdy) begin
        row_q.push_back(in_data);
        if (row_q.size() == RL) begin
          exp_q.push_back(row_result(row_q));
          row_q.delete();
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready), int'(model_ready()));
      chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_max",   int'(out_max),   int'(exp_q[0][RW-1 -: DW]));
        chk("out_idx",   int'(out_idx),   int'(exp_q[0][EW +: IW]));
        chk("out_eqcnt", int'(out_eqcnt), int'(exp_q[0][EW-1:0]));
      end
      if (out_valid && out_ready) got_q.push_back({out_max, out_idx, out_eqcnt});
    end
  end

  task automatic expect_res(input string name, input int i, input int m,
                            input int ix, input int ec);
    logic [RW-1:0] r;
    chk({name, "_present"}, int'(got_q.size() > i), 1);
    if (got_q.size() > i) begin
      r = got_q[i];
      chk({name, "_max"}, int'(r[RW-1 -: DW]), m);
      chk({name, "_idx"}, int'(r[EW +: IW]), ix);
      chk({name, "_eqcnt"}, int'(r[EW-1:0]), ec);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    logic acc = 0;
    in_valid = 1;
    in_data  = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL push_timeout at %0t: element %0d not accepted in 200 cycles", $time, d);
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_max", int'(out_max), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1;
    idle(1);

    // Row with a tie on the maximum.
    got_q.delete();
    push(3); push(9); push(2); push(9);
    chk("t1_latency_valid", int'(out_valid), 1);
    idle(2);
    expect_res("t1", 0, 9, 1, 2);

    // Back-to-back rows, no input gaps.
    got_q.delete();
    push(0); push(0); push(0); push(0);
    push(15); push(1); push(15); push(14);
    idle(2);
    expect_res("t2a", 0, 0, 0, 4);
    expect_res("t2b", 1, 15, 0, 2);

    // Backpressure while holding a result.
    got_q.delete();
    out_ready = 0;
    push(1); push(2); push(3); push(4);
    in_valid = 1; in_data = 9;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_in_ready", int'(in_ready), 0);
      chk("t3_hold_max", int'(out_max), 4);
      chk("t3_hold_idx", int'(out_idx), 3);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    push(9); push(1); push(1); push(1);
    idle(2);
    expect_res("t3a", 0, 4, 3, 1);
    expect_res("t3b", 1, 9, 0, 1);

    // Flush mid-row with a concurrent element.
    got_q.delete();
    push(7); push(8);
    flush = 1; in_valid = 1; in_data = 15;
    @(negedge clk);
    chk("t4_flush_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    flush = 0; in_valid = 0;
    push(2); push(5); push(5); push(1);
    idle(2);
    chk("t4_count", got_q.size(), 1);
    expect_res("t4", 0, 5, 1, 2);

    // Asynchronous reset mid-row.
    got_q.delete();
    push(6); push(2);
    rst_n = 0;
    #1;
    chk("t5_rst_out_valid", int'(out_valid), 0);
    chk("t5_rst_out_max", int'(out_max), 0);
    chk("t5_rst_out_idx", int'(out_idx), 0);
    chk("t5_rst_out_eqcnt", int'(out_eqcnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    push(6); push(6); push(6); push(7);
    idle(2);
    chk("t5_count", got_q.size(), 1);
    expect_res("t5", 0, 7, 3, 1);

    // Random rows with random gaps and backpressure.
    got_q.delete();
    rand_mode = 1;
    for (int f = 0; f < 1000; f++) begin
      for (int e = 0; e < RL; e++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if (f % 2 == 0) push(DW'($urandom_range(0, 3)));
        else push(DW'($urandom_range(0, 15)));
      end
    end
    rand_mode = 0;
    @(posedge clk);
    #2;
    out_ready = 1;
    idle(4);
    chk("rand_rows_out", got_q.size(), 1000);
    chk("rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
